// File: rtl/hack_mem_pkg.sv
// Shared Hack data-memory definitions: bus widths, memory map and arbiter types.
// Imported by the RAM arbiter, its read-tag pipe and the bus interface.
package hack_mem_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;

  // Hack data memory map: RAM below MEM_RAM, memory-mapped I/O above it
  localparam logic [ADDR_W-1:0] MEM_RAM  = 15'h4000;
  localparam logic [ADDR_W-1:0] MEM_SW   = 15'h6001;
  localparam logic [ADDR_W-1:0] MEM_KEYS = 15'h6002;
  localparam logic [ADDR_W-1:0] MEM_LEDG = 15'h6003;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
    logic   oob;
  } rd_tag_t;

endpackage

// File: rtl/hack_ram_arbiter_if.sv
// Bus bundle between the CPU data port, secondary port B, HackRAM and the arbiter.
// The arbiter takes the slave view; the surrounding system drives the master view.
interface hack_ram_arbiter_if;
  import hack_mem_pkg::*;

  logic              cpu_valid;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_hold;
  logic [DATA_W-1:0] cpu_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_valid, cpu_we, cpu_addr, cpu_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  ram_rdata,
    output cpu_hold, cpu_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output ram_addr, ram_wdata, ram_we
  );

  modport master (
    output cpu_valid, cpu_we, cpu_addr, cpu_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output ram_rdata,
    input  cpu_hold, cpu_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_addr, ram_wdata, ram_we
  );

endinterface

// File: rtl/hack_rd_tag_pipe.sv
// RD_LAT-deep shift register carrying {valid, owner, oob} alongside each RAM read,
// so the returning data can be steered to the requester that issued it.
module hack_rd_tag_pipe
  import hack_mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t push_tag,
  output rd_tag_t ret_tag
);

  rd_tag_t stage [RD_LAT];

  // Reset empties the pipe so reads in flight at reset never return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= push_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign ret_tag = stage[RD_LAT-1];

endmodule

// File: rtl/hack_ram_arbiter.sv
// Shares the single-port HackRAM between the Hack CPU data port (fixed priority)
// and port B, with a starvation limit that forces one B grant over a held CPU.
//
// state     | meaning
// ST_NORMAL | CPU owns the RAM whenever it is valid; B gets idle cycles
// ST_FORCE  | B has waited MAX_WAIT cycles; B wins, a valid CPU is held once
module hack_ram_arbiter
  import hack_mem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RAM_TOP  = MEM_RAM,
  parameter int                MAX_WAIT = 8,
  parameter int                RD_LAT   = 1
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  hack_ram_arbiter_if.slave  bus
);

  // Force is entered on the cycle the count steps onto MAX_WAIT, so the
  // B grant lands on wait cycle MAX_WAIT+1.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  arb_state_t state;
  arb_state_t state_nxt;
  logic [7:0] starve_cnt;
  owner_t     owner;
  logic       b_oob;
  logic       b_waiting;
  rd_tag_t    push_tag;
  rd_tag_t    ret_tag;

  assign b_oob = (bus.b_addr >= RAM_TOP);

  always_comb begin
    owner = OWN_NONE;
    if (i_reset_n) begin
      if (state == ST_FORCE) begin
        if (bus.b_req) begin
          owner = OWN_B;
        end
      end else if (bus.cpu_valid) begin
        owner = OWN_CPU;
      end else if (bus.b_req) begin
        owner = OWN_B;
      end
    end
  end

  assign bus.b_gnt    = (owner == OWN_B);
  assign bus.cpu_hold = i_reset_n && (state == ST_FORCE) && bus.cpu_valid;
  assign b_waiting    = bus.b_req && !bus.b_gnt;

  // Out-of-range B accesses are acknowledged but never write the RAM
  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.ram_we    = 1'b0;
    case (owner)
      OWN_CPU: begin
        bus.ram_addr  = bus.cpu_addr;
        bus.ram_wdata = bus.cpu_wdata;
        bus.ram_we    = bus.cpu_we;
      end
      OWN_B: begin
        bus.ram_addr  = bus.b_addr;
        bus.ram_wdata = bus.b_wdata;
        bus.ram_we    = bus.b_we && !b_oob;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_NORMAL: begin
        if (b_waiting && (starve_cnt == WAIT_LAST)) begin
          state_nxt = ST_FORCE;
        end
      end
      ST_FORCE:  state_nxt = ST_NORMAL;
      default:   state_nxt = ST_NORMAL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= ST_NORMAL;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (b_waiting) begin
        starve_cnt <= starve_cnt + 8'd1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  assign push_tag = '{
    valid: ((owner == OWN_CPU) && !bus.cpu_we) || ((owner == OWN_B) && !bus.b_we),
    owner: owner,
    oob:   (owner == OWN_B) && b_oob
  };

  hack_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk      (i_clk),
    .rst_n    (i_reset_n),
    .push_tag (push_tag),
    .ret_tag  (ret_tag)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bus.cpu_rdata <= '0;
      bus.b_rdata   <= '0;
      bus.b_rvalid  <= 1'b0;
    end else begin
      bus.b_rvalid <= 1'b0;
      if (ret_tag.valid) begin
        if (ret_tag.owner == OWN_CPU) begin
          bus.cpu_rdata <= bus.ram_rdata;
        end else if (ret_tag.owner == OWN_B) begin
          bus.b_rdata  <= ret_tag.oob ? '0 : bus.ram_rdata;
          bus.b_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hack_ram_arbiter.sv
// Directed and randomized bench for hack_ram_arbiter with a behavioural HackRAM
// and a shadow-memory reference for grants, holds and read returns.
module tb_hack_ram_arbiter;
  import hack_mem_pkg::*;

  localparam int                MAX_WAIT = 8;
  localparam int                RD_LAT   = 1;
  localparam logic [ADDR_W-1:0] RAM_TOP  = 15'h4000;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  hack_ram_arbiter_if bus ();

  hack_ram_arbiter #(
    .RAM_TOP  (RAM_TOP),
    .MAX_WAIT (MAX_WAIT),
    .RD_LAT   (RD_LAT)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // HackRAM model: RAM region zeroed, region above RAM_TOP holds a marker
  logic [DATA_W-1:0] mem [0:32767];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  bit                mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 32768; i++) mem[i] <= (i >= 'h4000) ? 16'hDEAD : 16'h0000;
      mem_ready <= 1'b1;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    rd_pipe[0] <= mem[bus.ram_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.ram_rdata = rd_pipe[RD_LAT-1];

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%04h expected=%04h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.cpu_valid = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.b_req     = 1'b0;
    bus.b_we      = 1'b0;
    bus.b_addr    = '0;
    bus.b_wdata   = '0;
  endtask

  logic [15:0] wv, prev;
  logic [15:0] shadow [16];
  bit          eb_v [16];
  logic [15:0] eb_d [16];
  bit          ec_v [16];
  logic [15:0] ec_d [16];
  logic [15:0] exp_cpu_rdata;
  logic [3:0]  ci, bi;
  bit          b_oob, exp_g, exp_h, held, b_done;
  int          bwait;

  initial begin
    // reset with every request active: nothing may leak out
    rst_n = 1'b0;
    idle();
    bus.cpu_valid = 1'b1; bus.cpu_we = 1'b1;
    bus.b_req = 1'b1; bus.b_we = 1'b1;
    repeat (3) tick();
    mid();
    chk_b("rst_ram_we", bus.ram_we, 1'b0);
    chk_b("rst_b_gnt", bus.b_gnt, 1'b0);
    chk_b("rst_cpu_hold", bus.cpu_hold, 1'b0);
    chk_w("rst_cpu_rdata", bus.cpu_rdata, 16'h0000);
    chk_w("rst_b_rdata", bus.b_rdata, 16'h0000);
    chk_b("rst_b_rvalid", bus.b_rvalid, 1'b0);
    chk_b("rst_state", dut.state == ST_NORMAL, 1'b1);
    chk_w("rst_starve_cnt", 16'(dut.starve_cnt), 16'h0000);
    tick(); idle(); rst_n = 1'b1;

    // CPU only: write then read 0x0010, twice with different data
    prev = 16'h0000;
    for (int k = 0; k < 2; k++) begin
      wv = (k == 0) ? 16'hBEEF : 16'h5A5A;
      tick(); idle();
      bus.cpu_valid = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 15'h0010; bus.cpu_wdata = wv;
      mid();
      chk_b("cpu_wr_hold", bus.cpu_hold, 1'b0);
      chk_b("cpu_wr_we", bus.ram_we, 1'b1);
      chk_w("cpu_wr_wdata", bus.ram_wdata, wv);
      tick(); bus.cpu_we = 1'b0;
      mid();
      chk_b("cpu_rd_hold", bus.cpu_hold, 1'b0);
      chk_b("cpu_rd_we", bus.ram_we, 1'b0);
      chk_w("cpu_rd_addr", 16'(bus.ram_addr), 16'h0010);
      tick(); idle();
      for (int j = 1; j <= RD_LAT; j++) begin
        mid(); chk_w("cpu_rdata_early", bus.cpu_rdata, prev); tick();
      end
      mid(); chk_w("cpu_rdata", bus.cpu_rdata, wv);
      prev = wv;
    end

    // B only: write then read 0x0100
    tick(); idle();
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 15'h0100; bus.b_wdata = 16'h1234;
    mid();
    chk_b("b_wr_gnt", bus.b_gnt, 1'b1);
    chk_b("b_wr_we", bus.ram_we, 1'b1);
    chk_w("b_wr_addr", 16'(bus.ram_addr), 16'h0100);
    tick(); bus.b_we = 1'b0;
    mid();
    chk_b("b_rd_gnt", bus.b_gnt, 1'b1);
    chk_b("b_rd_we", bus.ram_we, 1'b0);
    tick(); idle();
    for (int j = 1; j <= RD_LAT; j++) begin
      mid(); chk_b("b_rvalid_early", bus.b_rvalid, 1'b0); tick();
    end
    mid();
    chk_b("b_rvalid", bus.b_rvalid, 1'b1);
    chk_w("b_rdata", bus.b_rdata, 16'h1234);
    tick(); mid();
    chk_b("b_rvalid_once", bus.b_rvalid, 1'b0);

    // starvation: CPU valid every cycle, B read held until forced grant
    tick(); idle();
    bus.cpu_valid = 1'b1; bus.cpu_addr = 15'h0010;
    bus.b_req = 1'b1; bus.b_addr = 15'h0100;
    for (int k = 1; k <= MAX_WAIT + 1; k++) begin
      mid();
      chk_b("starve_gnt", bus.b_gnt, k == MAX_WAIT + 1);
      chk_b("starve_hold", bus.cpu_hold, k == MAX_WAIT + 1);
      if (k < MAX_WAIT + 1) tick();
    end
    chk_w("starve_ram_addr", 16'(bus.ram_addr), 16'h0100);
    tick(); bus.b_req = 1'b0;
    for (int j = 1; j <= RD_LAT + 1; j++) begin
      mid();
      if (j == 1) begin
        chk_b("starve_hold_after", bus.cpu_hold, 1'b0);
        chk_w("starve_cpu_serviced", 16'(bus.ram_addr), 16'h0010);
      end
      chk_b("starve_b_rvalid", bus.b_rvalid, j == RD_LAT + 1);
      if (j < RD_LAT + 1) tick();
    end
    chk_w("starve_b_rdata", bus.b_rdata, 16'h1234);
    chk_w("starve_cpu_rdata", bus.cpu_rdata, 16'h5A5A);

    // reset while a B read is in flight
    tick(); idle();
    bus.cpu_valid = 1'b1; bus.cpu_addr = 15'h0010;
    bus.b_req = 1'b1; bus.b_addr = 15'h0100;
    repeat (3) begin mid(); tick(); end
    bus.cpu_valid = 1'b0;
    mid(); chk_b("rstmid_gnt", bus.b_gnt, 1'b1);
    tick();
    bus.cpu_valid = 1'b1; bus.cpu_we = 1'b1; bus.b_we = 1'b1;
    rst_n = 1'b0;
    mid();
    chk_b("rstmid_gnt_off", bus.b_gnt, 1'b0);
    chk_b("rstmid_hold_off", bus.cpu_hold, 1'b0);
    chk_b("rstmid_we_off", bus.ram_we, 1'b0);
    chk_w("rstmid_cpu_rdata", bus.cpu_rdata, 16'h0000);
    chk_w("rstmid_b_rdata", bus.b_rdata, 16'h0000);
    chk_b("rstmid_state", dut.state == ST_NORMAL, 1'b1);
    chk_w("rstmid_starve_cnt", 16'(dut.starve_cnt), 16'h0000);
    tick(); tick(); idle(); rst_n = 1'b1;
    for (int j = 0; j < RD_LAT + 2; j++) begin
      mid(); chk_b("rstmid_no_rvalid", bus.b_rvalid, 1'b0); tick();
    end
    mid(); chk_w("rstmid_b_rdata_after", bus.b_rdata, 16'h0000);

    // B out of range at 0x4000: write suppressed, read returns zero
    tick(); idle();
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 15'h4000; bus.b_wdata = 16'hFFFF;
    mid();
    chk_b("oob_wr_gnt", bus.b_gnt, 1'b1);
    chk_b("oob_wr_we", bus.ram_we, 1'b0);
    tick(); bus.b_we = 1'b0;
    mid();
    chk_b("oob_rd_gnt", bus.b_gnt, 1'b1);
    chk_b("oob_rd_we", bus.ram_we, 1'b0);
    tick(); idle();
    for (int j = 1; j <= RD_LAT; j++) begin
      mid(); chk_b("oob_rvalid_early", bus.b_rvalid, 1'b0); tick();
    end
    mid();
    chk_b("oob_rvalid", bus.b_rvalid, 1'b1);
    chk_w("oob_rdata", bus.b_rdata, 16'h0000);
    chk_w("oob_mem_unchanged", mem[15'h4000], 16'hDEAD);

    // simultaneous writes to 0x0020: CPU first, B next, last write wins
    tick(); idle();
    bus.cpu_valid = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 15'h0020; bus.cpu_wdata = 16'hAAAA;
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 15'h0020; bus.b_wdata = 16'h5555;
    mid();
    chk_b("dual_cpu_first_gnt", bus.b_gnt, 1'b0);
    chk_b("dual_cpu_first_hold", bus.cpu_hold, 1'b0);
    chk_w("dual_cpu_first_wdata", bus.ram_wdata, 16'hAAAA);
    tick(); bus.cpu_valid = 1'b0; bus.cpu_we = 1'b0;
    mid();
    chk_b("dual_b_next_gnt", bus.b_gnt, 1'b1);
    chk_b("dual_b_next_we", bus.ram_we, 1'b1);
    chk_w("dual_b_next_wdata", bus.ram_wdata, 16'h5555);
    tick(); idle();
    bus.cpu_valid = 1'b1; bus.cpu_addr = 15'h0020;
    mid(); tick(); idle();
    for (int j = 1; j <= RD_LAT; j++) begin mid(); tick(); end
    mid(); chk_w("dual_final_read", bus.cpu_rdata, 16'h5555);

    // randomized traffic against the shadow-memory model (addresses 0x200..0x20F)
    for (int i = 0; i < 16; i++) begin
      shadow[i] = 16'h0000; eb_v[i] = 1'b0; ec_v[i] = 1'b0; eb_d[i] = '0; ec_d[i] = '0;
    end
    exp_cpu_rdata = 16'h5555;
    bwait = 0; held = 1'b0; ci = '0; bi = '0; b_oob = 1'b0;
    tick(); idle();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!held) begin
        bus.cpu_valid = (cyc < 390) && ($urandom_range(99) < ((cyc < 200) ? 85 : 50));
        bus.cpu_we    = 1'($urandom_range(1));
        ci            = 4'($urandom_range(15));
        bus.cpu_addr  = {11'h020, ci};
        bus.cpu_wdata = 16'($urandom);
      end
      if (!bus.b_req) begin
        bus.b_req   = (cyc < 390) && ($urandom_range(99) < 40);
        bus.b_we    = 1'($urandom_range(1));
        b_oob       = ($urandom_range(3) == 0);
        bi          = 4'($urandom_range(15));
        bus.b_addr  = b_oob ? {11'h400, bi} : {11'h020, bi};
        bus.b_wdata = 16'($urandom);
        bwait       = 0;
      end
      // B wins when the CPU is idle or once it has waited MAX_WAIT cycles
      exp_g = bus.b_req && (!bus.cpu_valid || bwait == MAX_WAIT);
      exp_h = bus.cpu_valid && bus.b_req && bwait == MAX_WAIT;
      mid();
      chk_b("rnd_gnt", bus.b_gnt, exp_g);
      chk_b("rnd_hold", bus.cpu_hold, exp_h);
      if (ec_v[cyc % 16]) begin
        exp_cpu_rdata = ec_d[cyc % 16];
        ec_v[cyc % 16] = 1'b0;
      end
      chk_w("rnd_cpu_rdata", bus.cpu_rdata, exp_cpu_rdata);
      chk_b("rnd_b_rvalid", bus.b_rvalid, eb_v[cyc % 16]);
      if (eb_v[cyc % 16]) begin
        chk_w("rnd_b_rdata", bus.b_rdata, eb_d[cyc % 16]);
        eb_v[cyc % 16] = 1'b0;
      end
      b_done = exp_g;
      if (exp_g) begin
        if (!bus.b_we) begin
          eb_v[(cyc + RD_LAT + 1) % 16] = 1'b1;
          eb_d[(cyc + RD_LAT + 1) % 16] = b_oob ? 16'h0000 : shadow[bi];
        end else if (!b_oob) begin
          shadow[bi] = bus.b_wdata;
        end
      end else if (bus.b_req) begin
        bwait++;
      end
      if (bus.cpu_valid && !exp_h && !exp_g) begin
        if (bus.cpu_we) begin
          shadow[ci] = bus.cpu_wdata;
        end else begin
          ec_v[(cyc + RD_LAT + 1) % 16] = 1'b1;
          ec_d[(cyc + RD_LAT + 1) % 16] = shadow[ci];
        end
      end
      held = exp_h;
      tick();
      if (b_done) bus.b_req = 1'b0;
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
